// File: rtl/mtimer_pkg.sv
// Shared register map, reset values and byte-merge helper for the machine timer.
package mtimer_pkg;

    localparam logic [4:0]  MTIME_LO_OFS    = 5'h00;
    localparam logic [4:0]  MTIME_HI_OFS    = 5'h04;
    localparam logic [4:0]  MTIMECMP_LO_OFS = 5'h08;
    localparam logic [4:0]  MTIMECMP_HI_OFS = 5'h0C;
    localparam logic [4:0]  CTRL_OFS        = 5'h10;
    localparam logic [4:0]  PRESCALE_OFS    = 5'h14;

    localparam int          CTRL_EN_BIT     = 0;
    localparam logic [63:0] MTIMECMP_RST    = 64'hFFFF_FFFF_FFFF_FFFF;

    // Replace each byte of old_v with the matching byte of new_v where its enable is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mtimer_tick_gen.sv
// Prescale counter for the machine timer: counts 0..prescale while enabled and
// pulses tick on the wrap cycle, so prescale=0 ticks every enabled cycle.
module mtimer_tick_gen #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_r;
    logic                  wrap_s;

    // >= rather than == keeps the counter bounded even if it ever overshoots prescale.
    assign wrap_s = (cnt_r >= prescale);
    assign tick   = en & wrap_s;

    // Prescale counter: cleared by reset or a prescale write, frozen while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {PRESCALE_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {PRESCALE_W{1'b0}};
        end else if (en) begin
            if (wrap_s) begin
                cnt_r <= {PRESCALE_W{1'b0}};
            end else begin
                cnt_r <= cnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) on a zero-wait OBI slave port, driving a level irq.
// Optional MTIMER_SNAPSHOT_EN: MTIME_LO reads latch mtime[63:32] so MTIME_HI reads are tear-free.
module mtimer
    import mtimer_pkg::*;
#(
    parameter int PRESCALE_W = 16,
    parameter int ADDR_W     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              gnt,
    output logic              rvalid,
    output logic [31:0]       rdata,
    output logic              irq_timer
);

    localparam logic [ADDR_W-1:0] OFS_MASK = ~ADDR_W'(32'd3);

    logic [63:0]           mtime_r;
    logic [63:0]           mtimecmp_r;
    logic                  en_r;
    logic [PRESCALE_W-1:0] prescale_r;
    logic                  rvalid_r;
    logic [31:0]           rdata_r;
    logic                  irq_r;
`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0]           shadow_r;
`endif

    logic [ADDR_W-1:0]     ofs_s;
    logic                  wr_s;
    logic                  rd_s;
    logic                  tick_s;
    logic                  prescale_wr_s;
    logic [31:0]           rd_data_s;
    logic [63:0]           mtime_inc_s;
    logic [63:0]           mtime_nxt_s;
    logic [63:0]           mtimecmp_nxt_s;
    logic                  en_nxt_s;
    logic [PRESCALE_W-1:0] prescale_nxt_s;

    assign gnt       = req;
    assign rvalid    = rvalid_r;
    assign rdata     = rdata_r;
    assign irq_timer = irq_r;

    assign ofs_s       = addr & OFS_MASK;
    assign wr_s        = req & we;
    assign rd_s        = req & ~we;
    assign mtime_inc_s = tick_s ? (mtime_r + 64'd1) : mtime_r;

    mtimer_tick_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (en_r),
        .clr      (prescale_wr_s),
        .prescale (prescale_r),
        .tick     (tick_s)
    );

    // Read mux over the current (pre-update) register values.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (ofs_s)
            ADDR_W'(MTIME_LO_OFS):    rd_data_s = mtime_r[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            ADDR_W'(MTIME_HI_OFS):    rd_data_s = shadow_r;
`else
            ADDR_W'(MTIME_HI_OFS):    rd_data_s = mtime_r[63:32];
`endif
            ADDR_W'(MTIMECMP_LO_OFS): rd_data_s = mtimecmp_r[31:0];
            ADDR_W'(MTIMECMP_HI_OFS): rd_data_s = mtimecmp_r[63:32];
            ADDR_W'(CTRL_OFS):        rd_data_s[CTRL_EN_BIT] = en_r;
            ADDR_W'(PRESCALE_OFS):    rd_data_s = 32'(prescale_r);
            default:                  rd_data_s = 32'h0000_0000;
        endcase
    end

    // Next-state for writable registers; a write racing a tick merges bytes over mtime+1.
    always_comb begin
        mtime_nxt_s    = mtime_inc_s;
        mtimecmp_nxt_s = mtimecmp_r;
        en_nxt_s       = en_r;
        prescale_nxt_s = prescale_r;
        prescale_wr_s  = 1'b0;
        if (wr_s) begin
            case (ofs_s)
                ADDR_W'(MTIME_LO_OFS):
                    mtime_nxt_s[31:0] = be_merge(mtime_inc_s[31:0], wdata, be);
                ADDR_W'(MTIME_HI_OFS):
                    mtime_nxt_s[63:32] = be_merge(mtime_inc_s[63:32], wdata, be);
                ADDR_W'(MTIMECMP_LO_OFS):
                    mtimecmp_nxt_s[31:0] = be_merge(mtimecmp_r[31:0], wdata, be);
                ADDR_W'(MTIMECMP_HI_OFS):
                    mtimecmp_nxt_s[63:32] = be_merge(mtimecmp_r[63:32], wdata, be);
                ADDR_W'(CTRL_OFS): begin
                    if (be[0]) begin
                        en_nxt_s = wdata[CTRL_EN_BIT];
                    end else begin
                        en_nxt_s = en_r;
                    end
                end
                ADDR_W'(PRESCALE_OFS): begin
                    prescale_wr_s = 1'b1;
                    for (int i = 0; i < PRESCALE_W; i++) begin
                        if (be[i >> 3]) begin
                            prescale_nxt_s[i] = wdata[i];
                        end else begin
                            prescale_nxt_s[i] = prescale_r[i];
                        end
                    end
                end
                default: begin
                    mtime_nxt_s = mtime_inc_s;
                end
            endcase
        end else begin
            mtime_nxt_s = mtime_inc_s;
        end
    end

    // Register state, bus response and the level interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_r    <= 64'h0000_0000_0000_0000;
            mtimecmp_r <= MTIMECMP_RST;
            en_r       <= 1'b0;
            prescale_r <= {PRESCALE_W{1'b0}};
            rvalid_r   <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            irq_r      <= 1'b0;
        end else begin
            mtime_r    <= mtime_nxt_s;
            mtimecmp_r <= mtimecmp_nxt_s;
            en_r       <= en_nxt_s;
            prescale_r <= prescale_nxt_s;
            rvalid_r   <= req;
            if (rd_s) begin
                rdata_r <= rd_data_s;
            end else if (req) begin
                rdata_r <= 32'h0000_0000;
            end else begin
                rdata_r <= rdata_r;
            end
            irq_r <= en_r & (mtime_r >= mtimecmp_r);
        end
    end

`ifdef MTIMER_SNAPSHOT_EN
    // Shadow of mtime[63:32]: captured on MTIME_LO reads, also follows MTIME_HI writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= 32'h0000_0000;
        end else if (rd_s && (ofs_s == ADDR_W'(MTIME_LO_OFS))) begin
            shadow_r <= mtime_r[63:32];
        end else if (wr_s && (ofs_s == ADDR_W'(MTIME_HI_OFS))) begin
            shadow_r <= mtime_nxt_s[63:32];
        end else begin
            shadow_r <= shadow_r;
        end
    end
`endif

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: directed scenarios plus a randomized run against a
// cycle-level reference model of the timer's register rules.
module tb_mtimer;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        irq_timer;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic [15:0] m_pre;
    int          m_cnt;
    logic        m_irq;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [31:0] m_shadow;

    always #5 clk = ~clk;

    mtimer dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .be        (be),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .irq_timer (irq_timer)
    );

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (b[k]) r[k*8 +: 8] = n[k*8 +: 8];
        return r;
    endfunction

    function automatic void model_reset();
        m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_en = 1'b0; m_pre = 16'd0;
        m_cnt = 0; m_irq = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0; m_shadow = 32'd0;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_step();
        logic        tick;
        logic        irq_n;
        logic [31:0] rd;
        logic [63:0] mt;
        int          w;
        if (rst) begin
            model_reset();
            return;
        end
        w     = int'(addr) / 4;
        tick  = m_en && (m_cnt == int'(m_pre));
        irq_n = m_en && (m_mtime >= m_cmp);
        case (w)
            0: rd = m_mtime[31:0];
`ifdef MTIMER_SNAPSHOT_EN
            1: rd = m_shadow;
`else
            1: rd = m_mtime[63:32];
`endif
            2: rd = m_cmp[31:0];
            3: rd = m_cmp[63:32];
            4: rd = {31'd0, m_en};
            5: rd = {16'd0, m_pre};
            default: rd = 32'd0;
        endcase
        mt = tick ? m_mtime + 64'd1 : m_mtime;
        if (m_en) m_cnt = tick ? 0 : m_cnt + 1;
        if (req && !we && w == 0) m_shadow = m_mtime[63:32];
        if (req && we) begin
            case (w)
                0: mt[31:0]  = merge(mt[31:0], wdata, be);
                1: begin mt[63:32] = merge(mt[63:32], wdata, be); m_shadow = mt[63:32]; end
                2: m_cmp[31:0]  = merge(m_cmp[31:0], wdata, be);
                3: m_cmp[63:32] = merge(m_cmp[63:32], wdata, be);
                4: if (be[0]) m_en = wdata[0];
                5: begin m_pre = merge({16'd0, m_pre}, wdata, be) & 32'h0000_FFFF; m_cnt = 0; end
                default: ;
            endcase
        end
        m_mtime  = mt;
        m_irq    = irq_n;
        m_rvalid = req;
        if (req) m_rdata = we ? 32'd0 : rd;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [3:0] b,
                         input logic [4:0] a, input logic [31:0] d);
        req = r; we = w; be = b; addr = a; wdata = d;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b0, 4'hF, 5'h08, 32'd0);
        drive(1'b1, 1'b0, 4'hF, 5'h08, 32'd0);
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %b want 0", rvalid); end
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        n_tests++; if (irq_timer !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq_timer); end
        rst = 1'b0; req = 1'b0; #1;
        n_tests++; if (gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %b want 0", gnt); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 4'hF, (i == 0) ? 5'h08 : 5'h0C, 32'd0);
            n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL cmp_rvalid: got %b want 1", rvalid); end
            n_tests++; if (rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cmp_rst_read: got %h want ffffffff", rdata); end
        end
        drive(1'b0, 1'b0, 4'h0, 5'h00, 32'd0);
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_single: got %b want 0", rvalid); end
        n_tests++; if (irq_timer !== 1'b0) begin n_fail++; $display("FAIL rst_irq_idle: got %b want 0", irq_timer); end
    endtask

    task automatic test_cmp_irq();
        drive(1'b1, 1'b1, 4'hF, 5'h08, 32'd10);
        drive(1'b1, 1'b1, 4'hF, 5'h0C, 32'd0);
        drive(1'b1, 1'b1, 4'hF, 5'h14, 32'd0);
        drive(1'b1, 1'b1, 4'hF, 5'h10, 32'd1);
        // mtime equals k after the k-th enabled edge; irq follows one edge after mtime hits 10
        for (int k = 1; k <= 20; k++) begin
            drive(1'b0, 1'b0, 4'h0, 5'h00, 32'd0);
            n_tests++;
            if (irq_timer !== (k >= 11)) begin
                n_fail++; $display("FAIL irq_rise k=%0d: got %b want %b", k, irq_timer, (k >= 11));
            end
        end
        drive(1'b1, 1'b1, 4'hF, 5'h10, 32'd0);
        drive(1'b0, 1'b0, 4'h0, 5'h00, 32'd0);
        n_tests++; if (irq_timer !== 1'b0) begin n_fail++; $display("FAIL irq_clear_en: got %b want 0", irq_timer); end
    endtask

    task automatic test_prescale();
        drive(1'b1, 1'b1, 4'hF, 5'h00, 32'd0);
        drive(1'b1, 1'b1, 4'hF, 5'h04, 32'd0);
        drive(1'b1, 1'b1, 4'hF, 5'h14, 32'd3);
        drive(1'b1, 1'b1, 4'hF, 5'h10, 32'd1);
        for (int k = 0; k < 39; k++) begin
            drive(1'b0, 1'b0, 4'h0, 5'h00, 32'd0);
            n_tests++; if (irq_timer !== m_irq) begin n_fail++; $display("FAIL pre_irq: got %b want %b", irq_timer, m_irq); end
        end
        drive(1'b1, 1'b1, 4'hF, 5'h10, 32'd0);
        drive(1'b1, 1'b0, 4'hF, 5'h00, 32'd0);
        n_tests++; if (rdata !== 32'd10) begin n_fail++; $display("FAIL pre_mtime: got %0d want 10", rdata); end
        for (int k = 0; k < 20; k++) drive(1'b0, 1'b0, 4'h0, 5'h00, 32'd0);
        drive(1'b1, 1'b0, 4'hF, 5'h00, 32'd0);
        n_tests++; if (rdata !== 32'd10) begin n_fail++; $display("FAIL pre_frozen: got %0d want 10", rdata); end
        n_tests++; if (irq_timer !== 1'b0) begin n_fail++; $display("FAIL pre_irq_off: got %b want 0", irq_timer); end
    endtask

    task automatic test_carry_bytes();
        drive(1'b1, 1'b1, 4'hF, 5'h14, 32'd0);
        drive(1'b1, 1'b1, 4'hF, 5'h00, 32'hFFFF_FFFF);
        drive(1'b1, 1'b1, 4'hF, 5'h04, 32'd0);
        drive(1'b1, 1'b1, 4'hF, 5'h10, 32'd1);
        drive(1'b1, 1'b1, 4'hF, 5'h10, 32'd0);
        drive(1'b1, 1'b0, 4'hF, 5'h00, 32'd0);
        n_tests++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL carry_lo: got %h want 0", rdata); end
        drive(1'b1, 1'b0, 4'hF, 5'h04, 32'd0);
        n_tests++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL carry_hi: got %h want 1", rdata); end
        drive(1'b1, 1'b1, 4'b0001, 5'h00, 32'h1234_56AA);
        drive(1'b1, 1'b0, 4'hF, 5'h00, 32'd0);
        n_tests++; if (rdata !== 32'h0000_00AA) begin n_fail++; $display("FAIL be_lo: got %h want 000000aa", rdata); end
        drive(1'b1, 1'b0, 4'hF, 5'h04, 32'd0);
        n_tests++; if (rdata !== 32'd1) begin n_fail++; $display("FAIL be_hi: got %h want 1", rdata); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  a_tab [4] = '{5'h00, 5'h00, 5'h18, 5'h04};
        logic        w_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] e_tab [4] = '{32'h0, 32'h55, 32'h0, 32'h1};
        for (int i = 0; i < 4; i++) begin
            req = 1'b1; we = w_tab[i]; be = 4'hF; addr = a_tab[i]; wdata = 32'h55;
            #1;
            n_tests++; if (gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt %0d: got %b want 1", i, gnt); end
            model_step();
            @(posedge clk);
            #1;
            n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid %0d: got %b want 1", i, rvalid); end
            if (!w_tab[i]) begin
                n_tests++; if (rdata !== e_tab[i]) begin n_fail++; $display("FAIL b2b_rdata %0d: got %h want %h", i, rdata, e_tab[i]); end
            end
        end
        drive(1'b0, 1'b0, 4'h0, 5'h00, 32'd0);
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", rvalid); end
    endtask

    task automatic test_snapshot();
        logic [31:0] exp_hi;
`ifdef MTIMER_SNAPSHOT_EN
        exp_hi = 32'd1;
`else
        exp_hi = 32'd2;
`endif
        drive(1'b1, 1'b1, 4'hF, 5'h14, 32'd0);
        drive(1'b1, 1'b1, 4'hF, 5'h00, 32'hFFFF_FFFE);
        drive(1'b1, 1'b1, 4'hF, 5'h04, 32'd1);
        drive(1'b1, 1'b1, 4'hF, 5'h10, 32'd1);
        drive(1'b1, 1'b0, 4'hF, 5'h00, 32'd0);
        n_tests++; if (rdata !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL snap_lo: got %h want fffffffe", rdata); end
        drive(1'b0, 1'b0, 4'h0, 5'h00, 32'd0);
        drive(1'b1, 1'b0, 4'hF, 5'h04, 32'd0);
        n_tests++; if (rdata !== exp_hi) begin n_fail++; $display("FAIL snap_hi: got %h want %h", rdata, exp_hi); end
        drive(1'b1, 1'b1, 4'hF, 5'h10, 32'd0);
    endtask

    task automatic test_random();
        int          op;
        logic [4:0]  a;
        logic [31:0] d;
        for (int c = 0; c < 400; c++) begin
            rst = (($urandom % 100) == 0);
            op  = $urandom_range(0, 3);
            a   = 5'(($urandom_range(0, 7) * 4) + $urandom_range(0, 3));
            d   = (a[4:2] == 3'd5) ? 32'($urandom_range(0, 3)) :
                  (a[4:2] == 3'd1 || a[4:2] == 3'd3) ? 32'($urandom_range(0, 2)) : $urandom;
            case (op)
                0:       drive(1'b0, 1'b0, 4'h0, a, d);
                1:       drive(1'b1, 1'b0, 4'hF, a, d);
                default: drive(1'b1, 1'b1, 4'($urandom_range(0, 15)), a, d);
            endcase
            n_tests++; if (irq_timer !== m_irq) begin n_fail++; $display("FAIL rnd_irq c=%0d: got %b want %b", c, irq_timer, m_irq); end
            n_tests++; if (rvalid !== m_rvalid) begin n_fail++; $display("FAIL rnd_rvalid c=%0d: got %b want %b", c, rvalid, m_rvalid); end
            if (op == 1) begin
                n_tests++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata c=%0d a=%h: got %h want %h", c, a, rdata, m_rdata); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 5'h00; wdata = 32'd0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_cmp_irq();
        test_prescale();
        test_carry_bytes();
        test_back_to_back();
        test_snapshot();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
